// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment constants and the active-high hex glyph table.
package sseg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;
  // segment order {g,f,e,d,c,b,a}; A,b,C,d,E,F use the usual mixed-case shapes
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: combinational nibble to active-high seven-segment glyph lookup.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);
  assign seg = GLYPH[nib];
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: double-buffered multiplexed seven-segment driver with anti-ghost guard.
// Optional leading-zero blanking when SSEG_LEADING_ZERO_BLANK_EN is defined.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  enable,
  output logic [DIGITS-1:0]     an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic POL = ACTIVE_LOW != 0;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend_val, disp_val;
  logic [DIGITS-1:0]     pend_dp, disp_dp, lz;
  logic [SEG_W-1:0]      glyph;
  logic                  wrap, last, boundary, lit;

  assign wrap     = presc == PW'(REFRESH_DIV - 1);
  assign last     = idx == IW'(DIGITS - 1);
  assign boundary = enable && wrap && last;
  assign lit      = enable && 32'(presc) >= GUARD_CYCLES && !lz[idx];

  hex_to_sseg u_dec (
    .nib (disp_val[4*idx +: 4]),
    .seg (glyph)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic zero;
  // a digit is suppressed only if it and every more-significant nibble is zero
  always_comb begin
    lz   = '0;
    zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero  = zero && disp_val[4*i +: 4] == 4'h0;
      lz[i] = zero && !disp_dp[i];
    end
  end
`else
  assign lz = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc      <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      an         <= {DIGITS{POL}};
      seg        <= {SEG_W{POL}};
      dp         <= POL;
      frame_done <= 1'b0;
    end else begin
      if (load) {pend_val, pend_dp} <= {value, dp_in};
      // newest data wins when a load lands on the frame boundary
      if (!enable || boundary)
        {disp_val, disp_dp} <= load ? {value, dp_in} : {pend_val, pend_dp};
      presc <= !enable || wrap ? '0 : presc + 1'b1;
      if (!enable) idx <= '0;
      else if (wrap) idx <= last ? '0 : idx + 1'b1;
      frame_done <= boundary;
      an         <= {DIGITS{POL}} ^ (lit ? DIGITS'(1) << idx : '0);
      seg        <= {SEG_W{POL}} ^ (lit ? glyph : SEG_BLANK);
      dp         <= POL ^ (lit && disp_dp[idx]);
    end
  end
endmodule
